// File: rtl/cpu_controller_pkg.sv
// Shared types for the RISC core sequencer: IR opcode encoding and controller state.
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    // States 0..7 form the fetch/execute ring; HALTED sits outside it and reports phase 4.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    function automatic logic [2:0] phase_of(input state_t s);
        return (s == HALTED) ? 3'd4 : s[2:0];
    endfunction

    function automatic logic is_alu_op(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Fetch/execute sequencer: eight-state ring plus a terminal HALTED state,
// with memory/IR/PC/accumulator strobes decoded combinationally from the state.
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       halt,
    output logic [2:0] phase
);

    state_t  state_reg;
    state_t  state_next;
    state_t  dec_state;
    opcode_t op;
    logic    alu_op;

    assign op     = opcode_t'(opcode);
    assign alu_op = is_alu_op(op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INST_ADDR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INST_ADDR:  state_next = INST_FETCH;
            INST_FETCH: state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR:    state_next = (op == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE:      state_next = INST_ADDR;
            HALTED:     state_next = HALTED;
            default:    state_next = INST_ADDR;
        endcase
    end

    // While reset is held the strobes already show INST_ADDR, not the stale state.
    assign dec_state = rst ? INST_ADDR : state_reg;
    assign phase     = phase_of(dec_state);

    always_comb begin
        sel     = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        halt    = 1'b0;
        case (dec_state)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (op == HLT);
            end
            OP_FETCH: begin
                mem_rd = alu_op;
            end
            ALU_OP: begin
                mem_rd  = alu_op;
                load_ac = alu_op;
                inc_pc  = (op == SKZ) && zero;
                load_pc = (op == JMP);
            end
            STORE: begin
                mem_rd  = alu_op;
                load_ac = alu_op;
                inc_pc  = (op == JMP);
                load_pc = (op == JMP);
                mem_wr  = (op == STO);
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

    a_opcode_known: assert property (@(posedge clk) disable iff (rst)
        (state_reg inside {OP_ADDR, OP_FETCH, ALU_OP, STORE}) |-> !$isunknown(opcode));

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a phase model predicts every cycle's strobes,
// the driver queues the prediction and a negedge monitor compares it against the DUT.
module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    int   m_phase  = 0;
    logic m_halted = 1'b0;

    cpu_controller dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .sel     (sel),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .inc_pc  (inc_pc),
        .load_pc (load_pc),
        .halt    (halt),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (phase,sel,rd,wr,ir,ac,inc,ldpc,halt)", tag, got, exp);
        end
    endtask

    // Expected {phase, sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}
    function automatic logic [10:0] expected(input int ph, input logic hlt_st, input logic r,
                                             input logic [2:0] op, input logic z);
        logic [2:0] p;
        logic s, rd, wr, ir, ac, inc, ldpc, h, alu;
        s = 0; rd = 0; wr = 0; ir = 0; ac = 0; inc = 0; ldpc = 0; h = 0;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        p = r ? 3'd0 : (hlt_st ? 3'd4 : 3'(ph));
        if (!r && hlt_st) begin
            h = 1;
        end else begin
            case (p)
                3'd0: s = 1;
                3'd1: begin s = 1; rd = 1; end
                3'd2, 3'd3: begin s = 1; rd = 1; ir = 1; end
                3'd4: begin inc = 1; h = (op == 3'd0); end
                3'd5: rd = alu;
                3'd6: begin rd = alu; ac = alu; inc = (op == 3'd1) && z; ldpc = (op == 3'd7); end
                default: begin
                    rd = alu; ac = alu; inc = (op == 3'd7); ldpc = (op == 3'd7); wr = (op == 3'd6);
                end
            endcase
        end
        return {p, s, rd, wr, ir, ac, inc, ldpc, h};
    endfunction

    // One clock: advance the model across the edge with the inputs it saw, then drive new inputs.
    task automatic step(input logic r, input logic [2:0] op, input logic z);
        @(posedge clk);
        if (rst) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % 8;
        end
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        exp_q.push_back(expected(m_phase, m_halted, r, op, z));
        tag_q.push_back($sformatf("r%0d_op%0d_z%0d_ph%0d_h%0d", r, op, z, m_phase, m_halted));
    endtask

    // Eight clocks of one instruction; opcode is randomised in the don't-care phases 0..3.
    task automatic run_instr(input logic [2:0] op, input logic [7:0] zmask);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i < 4) ? 3'($urandom_range(0, 7)) : op, zmask[i]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(),
                     {phase, sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt},
                     exp_q.pop_front());
        end
    end

    initial begin
        rst    = 1'b1;
        opcode = 3'd5;
        zero   = 1'b0;
        step(1'b1, 3'd5, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        run_instr(3'd5, 8'h00);   // LDA
        run_instr(3'd1, 8'hFF);   // SKZ taken
        run_instr(3'd1, 8'h00);   // SKZ not taken
        run_instr(3'd1, 8'h20);   // zero only in OP_FETCH: ignored
        run_instr(3'd1, 8'hDF);   // zero everywhere but OP_FETCH
        run_instr(3'd7, 8'h00);   // JMP
        run_instr(3'd6, 8'hFF);   // STO
        run_instr(3'd2, 8'h55);
        run_instr(3'd3, 8'hAA);
        run_instr(3'd4, 8'h0F);
        for (int i = 0; i < 26; i++) step(1'b0, 3'd0, i[0]);  // HLT then 20+ clks halted
        step(1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 3'd2, 1'b0);   // walk to ALU_OP
        step(1'b1, 3'd2, 1'b0);                               // reset mid-instruction
        run_instr(3'd5, 8'h00);
        @(negedge clk);
        #1;
        check_eq("queue_drained", 11'(exp_q.size()), 11'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
